// File: rtl/memlcd_frame_sched_if.sv
// rtl/memlcd_frame_sched_if.sv - framebuffer read port and pixel FIFO write port bundle
interface memlcd_frame_sched_if #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 17
);
  logic                  mem_en;
  logic [ADDR_WIDTH:0]   mem_addr;
  logic [DATA_WIDTH-1:0] mem_data;
  logic                  wfull;
  logic                  winc;
  logic [DATA_WIDTH-1:0] wdata;

  modport master (
    output mem_en, mem_addr, winc, wdata,
    input  mem_data, wfull
  );

  modport slave (
    input  mem_en, mem_addr, winc, wdata,
    output mem_data, wfull
  );
endinterface

// File: rtl/memlcd_frame_sched.sv
// rtl/memlcd_frame_sched.sv - streams one framebuffer frame into the pixel FIFO per request, toggling VCOM per frame
// Optional periodic auto-refresh requests: define MEMLCD_SCHED_AUTOREFRESH_EN.
module memlcd_frame_sched #(
  parameter int DATA_WIDTH     = 8,
  parameter int LINE_BYTES     = 120,
  parameter int LINES          = 640,
  parameter int ADDR_WIDTH     = 17,
  parameter int REFRESH_CYCLES = 1000000
) (
  input  logic                       i_clk,
  input  logic                       i_reset,
  input  logic                       i_frame_req,
  input  logic                       i_buf_sel,
  memlcd_frame_sched_if.master       bus,
  output logic                       o_busy,
  output logic                       o_frame_done,
  output logic                       o_vcom
);
  localparam logic [ADDR_WIDTH-1:0] LAST_OFFSET = ADDR_WIDTH'(LINE_BYTES * LINES - 1);

  if ((2 ** ADDR_WIDTH) < (LINE_BYTES * LINES) || REFRESH_CYCLES < 2) begin : g_bad_cfg
    $error("memlcd_frame_sched: ADDR_WIDTH too small for one frame or REFRESH_CYCLES < 2");
  end

  typedef enum logic [2:0] {S_IDLE, S_READ, S_CAPT, S_WRITE, S_DONE} state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] offset_q, offset_d;
  logic                  buf_q, buf_d;
  logic                  pending_q, pending_d;
  logic                  busy_q, busy_d;
  logic                  mem_en_q, mem_en_d;
  logic [ADDR_WIDTH:0]   mem_addr_q, mem_addr_d;
  logic                  winc_q, winc_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic                  done_q, done_d;
  logic                  vcom_q, vcom_d;
  logic                  refresh_req;
  logic                  req_any;

  assign req_any = i_frame_req | refresh_req;

`ifdef MEMLCD_SCHED_AUTOREFRESH_EN
  localparam int RW = $clog2(REFRESH_CYCLES);
  localparam logic [RW-1:0] REFRESH_LAST = RW'(REFRESH_CYCLES - 1);
  logic [RW-1:0] refresh_cnt;
  logic          frame_start;

  assign frame_start = ((state_q == S_IDLE) || (state_q == S_DONE)) && (req_any || pending_q);
  assign refresh_req = (refresh_cnt == REFRESH_LAST);

  // Saturates at the terminal count so the request stays raised until a frame actually starts.
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset)                        refresh_cnt <= '0;
    else if (frame_start)               refresh_cnt <= '0;
    else if (refresh_cnt != REFRESH_LAST) refresh_cnt <= refresh_cnt + RW'(1);
  end
`else
  assign refresh_req = 1'b0;
`endif

  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      state_q    <= S_IDLE;
      offset_q   <= '0;
      buf_q      <= 1'b0;
      pending_q  <= 1'b0;
      busy_q     <= 1'b0;
      mem_en_q   <= 1'b0;
      mem_addr_q <= '0;
      winc_q     <= 1'b0;
      wdata_q    <= '0;
      done_q     <= 1'b0;
      vcom_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      offset_q   <= offset_d;
      buf_q      <= buf_d;
      pending_q  <= pending_d;
      busy_q     <= busy_d;
      mem_en_q   <= mem_en_d;
      mem_addr_q <= mem_addr_d;
      winc_q     <= winc_d;
      wdata_q    <= wdata_d;
      done_q     <= done_d;
      vcom_q     <= vcom_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    offset_d   = offset_q;
    buf_d      = buf_q;
    pending_d  = pending_q;
    busy_d     = busy_q;
    mem_en_d   = 1'b0;
    mem_addr_d = mem_addr_q;
    winc_d     = 1'b0;
    wdata_d    = wdata_q;
    done_d     = 1'b0;
    vcom_d     = vcom_q;

    case (state_q)
      S_IDLE: begin
        if (req_any || pending_q) begin
          buf_d     = i_buf_sel;
          busy_d    = 1'b1;
          pending_d = 1'b0;
          state_d   = S_READ;
        end
      end
      S_READ: begin
        if (req_any) pending_d = 1'b1;
        if (!bus.wfull) begin
          mem_en_d   = 1'b1;
          mem_addr_d = {buf_q, offset_q};
          state_d    = S_CAPT;
        end
      end
      S_CAPT: begin
        // RAM access cycle: read data appears on mem_data during the following WRITE state.
        if (req_any) pending_d = 1'b1;
        state_d = S_WRITE;
      end
      S_WRITE: begin
        if (req_any) pending_d = 1'b1;
        wdata_d = bus.mem_data;
        if (!bus.wfull) begin
          winc_d = 1'b1;
          if (offset_q == LAST_OFFSET) begin
            state_d = S_DONE;
          end else begin
            offset_d = offset_q + ADDR_WIDTH'(1);
            state_d  = S_READ;
          end
        end
      end
      S_DONE: begin
        done_d   = 1'b1;
        vcom_d   = ~vcom_q;
        offset_d = '0;
        // A pending or same-cycle request chains straight into the next frame with busy held.
        if (pending_q || req_any) begin
          buf_d     = i_buf_sel;
          pending_d = 1'b0;
          state_d   = S_READ;
        end else begin
          busy_d  = 1'b0;
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign bus.mem_en   = mem_en_q;
  assign bus.mem_addr = mem_addr_q;
  assign bus.winc     = winc_q;
  assign bus.wdata    = wdata_q;
  assign o_busy       = busy_q;
  assign o_frame_done = done_q;
  assign o_vcom       = vcom_q;
endmodule

// File: tb/tb_memlcd_frame_sched.sv
// tb/tb_memlcd_frame_sched.sv - directed self-checking bench for memlcd_frame_sched
module tb_memlcd_frame_sched;
  localparam int DW = 8;
  localparam int AW = 3;
  localparam int FRAME = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic frame_req = 1'b0;
  logic buf_sel = 1'b0;
  logic busy, frame_done, vcom;

  memlcd_frame_sched_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  memlcd_frame_sched #(
    .DATA_WIDTH(DW), .LINE_BYTES(4), .LINES(2), .ADDR_WIDTH(AW), .REFRESH_CYCLES(50)
  ) dut (
    .i_clk(clk), .i_reset(rst), .i_frame_req(frame_req), .i_buf_sel(buf_sel),
    .bus(bus), .o_busy(busy), .o_frame_done(frame_done), .o_vcom(vcom)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc = 0;
  int done_cnt = 0;
  int viol = 0;
  int req_cyc = 0;
  logic wf_prev = 1'b0;
  logic [DW-1:0] wq[$];
  logic [AW:0]   aq[$];
  int            dq[$];
  logic          bq[$];

  // Synchronous RAM model: buffer 0 holds offset+0x10, buffer 1 holds offset+0x80.
  always @(posedge clk)
    if (bus.mem_en)
      bus.mem_data <= (bus.mem_addr[AW] ? 8'h80 : 8'h10) + {5'b0, bus.mem_addr[AW-1:0]};

  always @(posedge clk) begin
    cyc     <= cyc + 1;
    wf_prev <= bus.wfull;
  end

  always @(negedge clk) begin
    if (bus.winc)   wq.push_back(bus.wdata);
    if (bus.mem_en) aq.push_back(bus.mem_addr);
    if ((bus.winc || bus.mem_en) && wf_prev) viol++;
    if (frame_done) begin
      done_cnt++;
      dq.push_back(cyc);
      bq.push_back(busy);
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic pulse_req(input logic b);
    @(negedge clk);
    frame_req = 1'b1;
    buf_sel   = b;
    req_cyc   = cyc;
    @(negedge clk);
    frame_req = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int target, input int max_cyc);
    int i;
    for (i = 0; i < max_cyc && done_cnt < target; i++) @(posedge clk);
    check_eq({tag, "_done_reached"}, done_cnt >= target, 1);
  endtask

  task automatic wait_writes(input int n, input int max_cyc);
    int i;
    for (i = 0; i < max_cyc && wq.size() < n; i++) @(posedge clk);
    check_eq("writes_reached", wq.size() >= n, 1);
  endtask

  task automatic clear_logs();
    wq.delete();
    aq.delete();
    dq.delete();
    bq.delete();
    viol = 0;
  endtask

  task automatic check_frames(input string tag, input int nfr, input logic bsel);
    check_eq({tag, "_nwrites"}, wq.size(), FRAME * nfr);
    check_eq({tag, "_nreads"}, aq.size(), FRAME * nfr);
    for (int i = 0; i < FRAME * nfr && i < wq.size() && i < aq.size(); i++) begin
      check_eq($sformatf("%s_data%0d", tag, i), wq[i], (bsel ? 32'h80 : 32'h10) + (i % FRAME));
      check_eq($sformatf("%s_addr%0d", tag, i), aq[i], (bsel ? 32'h8 : 32'h0) + (i % FRAME));
    end
    check_eq({tag, "_stall_viol"}, viol, 0);
  endtask

  initial begin
    bus.wfull = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("reset_outputs", {busy, frame_done, vcom, bus.mem_en, bus.winc, bus.wdata, bus.mem_addr}, 0);
    rst = 1'b0;

`ifdef MEMLCD_SCHED_AUTOREFRESH_EN
    clear_logs();
    wait_done("auto", 3, 250);
    check_eq("auto_period1", dq.size() >= 2 ? dq[1] - dq[0] : 0, 50);
    check_eq("auto_period2", dq.size() >= 3 ? dq[2] - dq[1] : 0, 50);
    check_eq("auto_first_data", wq.size() > 0 ? wq[0] : 0, 32'h10);
    check_eq("auto_last_data", wq.size() >= 8 ? wq[7] : 0, 32'h17);
    check_eq("auto_stall_viol", viol, 0);
`else
    // Single frame from buffer 0, no back-pressure
    clear_logs();
    pulse_req(1'b0);
    wait_done("t1", 1, 100);
    check_frames("t1", 1, 1'b0);
    check_eq("t1_latency", dq.size() > 0 ? dq[0] - req_cyc : 0, 26);
    check_eq("t1_vcom", vcom, 1);
    check_eq("t1_busy_at_done", bq.size() > 0 ? bq[0] : 1'b1, 0);

    // Buffer 1 latched at start; later buf_sel change ignored
    clear_logs();
    pulse_req(1'b1);
    repeat (6) @(negedge clk);
    buf_sel = 1'b0;
    wait_done("t2", 2, 100);
    check_frames("t2", 1, 1'b1);
    check_eq("t2_vcom", vcom, 0);

    // FIFO full for 10 cycles after the third write
    clear_logs();
    pulse_req(1'b0);
    wait_writes(3, 60);
    @(negedge clk);
    bus.wfull = 1'b1;
    repeat (10) @(negedge clk);
    bus.wfull = 1'b0;
    wait_done("t3", 3, 100);
    check_frames("t3", 1, 1'b0);
    check_eq("t3_vcom", vcom, 1);

    // Two requests while busy merge into exactly one back-to-back frame
    clear_logs();
    pulse_req(1'b0);
    repeat (4) @(negedge clk);
    pulse_req(1'b0);
    repeat (3) @(negedge clk);
    pulse_req(1'b0);
    wait_done("t4", 5, 150);
    repeat (80) @(posedge clk);
    check_eq("t4_frames", done_cnt, 5);
    check_frames("t4", 2, 1'b0);
    check_eq("t4_busy_held", bq.size() > 0 ? bq[0] : 1'b0, 1);
    check_eq("t4_b2b_spacing", dq.size() >= 2 ? dq[1] - dq[0] : 0, 25);
    check_eq("t4_vcom", vcom, 1);
    check_eq("t4_idle_busy", busy, 0);

    // Reset mid-frame aborts; next request restarts at offset 0
    clear_logs();
    pulse_req(1'b0);
    wait_writes(4, 60);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check_eq("t5_reset_outputs", {busy, frame_done, vcom, bus.mem_en, bus.winc, bus.wdata, bus.mem_addr}, 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(posedge clk);
    check_eq("t5_no_done_after_abort", done_cnt, 5);
    check_eq("t5_vcom_low", vcom, 0);
    clear_logs();
    pulse_req(1'b0);
    wait_done("t5", 6, 100);
    check_frames("t5", 1, 1'b0);
    check_eq("t5_vcom", vcom, 1);

    // Without auto-refresh nothing starts on its own
    repeat (300) @(posedge clk);
    check_eq("t6_no_auto_frames", done_cnt, 6);
    check_eq("t6_idle", busy, 0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
